// File: rtl/min_share_arb_pkg.sv
// Shared types and helpers for the min_share_arb arbiter and its registered min unit.
package min_share_arb_pkg;

  localparam int unsigned NREQ_MAX  = 8;
  localparam int unsigned IDX_W     = $clog2(NREQ_MAX);
  localparam int unsigned MIN_W_MAX = 64;

  // Next round-robin index after p, wrapping at n.
  function automatic logic [IDX_W-1:0] rr_next(input logic [IDX_W-1:0] p,
                                               input int unsigned n);
    if (32'(p) + 32'd1 >= n) return '0;
    return p + IDX_W'(1);
  endfunction

  // Unsigned minimum; on a tie operand a is returned.
  function automatic logic [MIN_W_MAX-1:0] min_sel(input logic [MIN_W_MAX-1:0] a,
                                                   input logic [MIN_W_MAX-1:0] b);
    return (a > b) ? b : a;
  endfunction

endpackage

// File: rtl/min_share_arb_if.sv
// Requester/response bundle between the clients and min_share_arb.
interface min_share_arb_if #(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8
);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       rsp_valid;
  logic [WIDTH-1:0]      rsp_data;
  logic [NREQ-1:0]       rsp_ready;

  modport master (
    output req_valid, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/min_share_arb_min2_reg.sv
// Registered unsigned two-input minimum with load enable.
module min_share_arb_min2_reg
  import min_share_arb_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      y <= '0;
    end else if (en) begin
      y <= WIDTH'(min_sel(MIN_W_MAX'(a), MIN_W_MAX'(b)));
    end
  end

endmodule

// File: rtl/min_share_arb.sv
// Round-robin arbiter sharing one registered min unit among NREQ requesters,
// with a single output slot that may drain and refill in the same cycle.
module min_share_arb
  import min_share_arb_pkg::*;
#(
  parameter int unsigned NREQ  = 4,
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  min_share_arb_if.slave     bus,
  output logic               busy,
  output logic [CNT_W-1:0]   op_count
);

  logic             out_valid;
  logic [IDX_W-1:0] owner;
  logic [IDX_W-1:0] ptr;
  logic             accept;
  logic             can_issue;
  logic             issue;
  logic             hit;
  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] cand;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] result;

  // Only the owner's rsp_ready can drain the slot.
  always_comb begin
    accept = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (out_valid && owner == IDX_W'(i) && bus.rsp_ready[i]) accept = 1'b1;
    end
  end

  assign can_issue = !out_valid || accept;

  // First valid requester after the pointer, in round-robin order.
  always_comb begin
    hit  = 1'b0;
    sel  = '0;
    cand = ptr;
    for (int k = 0; k < int'(NREQ); k++) begin
      cand = rr_next(cand, NREQ);
      if (!hit && |(bus.req_valid & (NREQ'(1) << cand))) begin
        hit = 1'b1;
        sel = cand;
      end
    end
  end

  // Grant is suppressed while reset is asserted so req_ready reads zero.
  assign issue = rst_n && can_issue && hit;

  always_comb begin
    bus.req_ready = '0;
    bus.rsp_valid = '0;
    op_a          = '0;
    op_b          = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (issue && sel == IDX_W'(i)) bus.req_ready[i] = 1'b1;
      if (out_valid && owner == IDX_W'(i)) bus.rsp_valid[i] = 1'b1;
      if (sel == IDX_W'(i)) begin
        op_a = bus.req_a[i*WIDTH +: WIDTH];
        op_b = bus.req_b[i*WIDTH +: WIDTH];
      end
    end
  end

  min_share_arb_min2_reg #(.WIDTH(WIDTH)) u_min2_reg (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (issue),
    .a     (op_a),
    .b     (op_b),
    .y     (result)
  );

  // Output slot, round-robin pointer and completed-operation counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      owner     <= '0;
      ptr       <= IDX_W'(NREQ - 1);
      op_count  <= '0;
    end else begin
      if (issue) begin
        out_valid <= 1'b1;
        owner     <= sel;
        ptr       <= sel;
      end else if (accept) begin
        out_valid <= 1'b0;
      end
      if (accept) op_count <= op_count + CNT_W'(1);
    end
  end

  assign bus.rsp_data = result;
  assign busy         = out_valid;

endmodule

// File: tb/tb_min_share_arb.sv
// Directed self-checking bench for min_share_arb (NREQ=4, WIDTH=8, CNT_W=4).
module tb_min_share_arb;

  localparam int unsigned NREQ  = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             busy;
  logic [CNT_W-1:0] op_count;
  int               errors = 0;
  int               checks = 0;

  min_share_arb_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

  min_share_arb #(.NREQ(NREQ), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .busy     (busy),
    .op_count (op_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = '1;
  endtask

  task automatic set_req(input int i, input logic [7:0] a, input logic [7:0] b);
    bus.req_a[i*WIDTH +: WIDTH] = a;
    bus.req_b[i*WIDTH +: WIDTH] = b;
    bus.req_valid[i]            = 1'b1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle_inputs();
    tick();
    tick();
    rst_n = 1'b1;
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    set_req(0, 8'h01, 8'h02);
    tick();
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL reset_req_ready: got %b exp 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data: got %h exp 00", bus.rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b exp 0", busy); end
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL reset_op_count: got %0d exp 0", op_count); end
  endtask

  task automatic test_single();
    do_reset();
    set_req(0, 8'h30, 8'h12);
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL single_grant: got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL single_rsp_valid: got %b exp 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h12) begin errors++; $display("FAIL single_rsp_data: got %h exp 12", bus.rsp_data); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b exp 1", busy); end
    tick();
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL single_op_count: got %0d exp 1", op_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle: got %b exp 0", busy); end
  endtask

  task automatic test_contention();
    logic [7:0] mins [4];
    mins = '{8'h10, 8'h03, 8'h77, 8'hFE};
    do_reset();
    set_req(0, 8'h10, 8'h20);
    set_req(1, 8'h05, 8'h03);
    set_req(2, 8'h77, 8'h77);
    set_req(3, 8'hFE, 8'hFF);
    #1;
    for (int k = 0; k < 6; k++) begin
      checks++; if (bus.req_ready !== 4'(1 << (k % 4))) begin errors++; $display("FAIL contend_grant[%0d]: got %b exp %b", k, bus.req_ready, 4'(1 << (k % 4))); end
      if (k > 0) begin
        checks++; if (bus.rsp_valid !== 4'(1 << ((k - 1) % 4))) begin errors++; $display("FAIL contend_rsp_valid[%0d]: got %b exp %b", k, bus.rsp_valid, 4'(1 << ((k - 1) % 4))); end
        checks++; if (bus.rsp_data !== mins[(k - 1) % 4]) begin errors++; $display("FAIL contend_rsp_data[%0d]: got %h exp %h", k, bus.rsp_data, mins[(k - 1) % 4]); end
      end
      tick();
    end
    bus.req_valid = '0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL contend_last_valid: got %b exp 0010", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h03) begin errors++; $display("FAIL contend_last_data: got %h exp 03", bus.rsp_data); end
    tick();
    checks++; if (op_count !== 4'd6) begin errors++; $display("FAIL contend_op_count: got %0d exp 6", op_count); end
  endtask

  task automatic test_backpressure();
    do_reset();
    bus.rsp_ready = 4'b1101;
    set_req(1, 8'h40, 8'h41);
    #1;
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL bp_grant1: got %b exp 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    set_req(0, 8'h09, 8'h08);
    set_req(2, 8'h2C, 8'h3C);
    for (int j = 0; j < 3; j++) begin
      #1;
      checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL bp_hold_ready[%0d]: got %b exp 0000", j, bus.req_ready); end
      checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL bp_hold_valid[%0d]: got %b exp 0010", j, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== 8'h40) begin errors++; $display("FAIL bp_hold_data[%0d]: got %h exp 40", j, bus.rsp_data); end
      tick();
    end
    bus.rsp_ready = 4'b1111;
    #1;
    checks++; if (bus.req_ready !== 4'b0100) begin errors++; $display("FAIL bp_release_grant: got %b exp 0100", bus.req_ready); end
    tick();
    bus.req_valid[2] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0100) begin errors++; $display("FAIL bp_rsp2_valid: got %b exp 0100", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h2C) begin errors++; $display("FAIL bp_rsp2_data: got %h exp 2c", bus.rsp_data); end
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL bp_grant0: got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL bp_rsp0_valid: got %b exp 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h08) begin errors++; $display("FAIL bp_rsp0_data: got %h exp 08", bus.rsp_data); end
    tick();
    checks++; if (op_count !== 4'd3) begin errors++; $display("FAIL bp_op_count: got %0d exp 3", op_count); end
  endtask

  task automatic test_boundaries();
    logic [7:0] va [4];
    logic [7:0] vb [4];
    logic [7:0] ve [4];
    va = '{8'h55, 8'h00, 8'hFF, 8'h80};
    vb = '{8'h55, 8'hFF, 8'h00, 8'h7F};
    ve = '{8'h55, 8'h00, 8'h00, 8'h7F};
    do_reset();
    for (int k = 0; k < 4; k++) begin
      set_req(3, va[k], vb[k]);
      #1;
      checks++; if (bus.req_ready !== 4'b1000) begin errors++; $display("FAIL bound_grant[%0d]: got %b exp 1000", k, bus.req_ready); end
      tick();
      bus.req_valid = '0;
      #1;
      checks++; if (bus.rsp_valid !== 4'b1000) begin errors++; $display("FAIL bound_valid[%0d]: got %b exp 1000", k, bus.rsp_valid); end
      checks++; if (bus.rsp_data !== ve[k]) begin errors++; $display("FAIL bound_data[%0d]: got %h exp %h", k, bus.rsp_data, ve[k]); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_req(2, 8'h05, 8'h06);
    #1;
    tick();
    bus.req_valid = '0;
    tick();
    bus.rsp_ready = '0;
    set_req(1, 8'h21, 8'h20);
    #1;
    tick();
    bus.req_valid = '0;
    set_req(0, 8'h66, 8'h65);
    #1;
    checks++; if (bus.rsp_valid !== 4'b0010) begin errors++; $display("FAIL mid_pre_valid: got %b exp 0010", bus.rsp_valid); end
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL mid_pre_count: got %0d exp 1", op_count); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.req_ready !== 4'b0000) begin errors++; $display("FAIL mid_rst_ready: got %b exp 0000", bus.req_ready); end
    checks++; if (bus.rsp_valid !== 4'b0000) begin errors++; $display("FAIL mid_rst_valid: got %b exp 0000", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h00) begin errors++; $display("FAIL mid_rst_data: got %h exp 00", bus.rsp_data); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b exp 0", busy); end
    checks++; if (op_count !== 4'd0) begin errors++; $display("FAIL mid_rst_count: got %0d exp 0", op_count); end
    bus.req_valid[1] = 1'b1;
    bus.rsp_ready    = '1;
    tick();
    rst_n = 1'b1;
    #1;
    checks++; if (bus.req_ready !== 4'b0001) begin errors++; $display("FAIL mid_first_grant: got %b exp 0001", bus.req_ready); end
    tick();
    bus.req_valid[0] = 1'b0;
    #1;
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL mid_rsp0_valid: got %b exp 0001", bus.rsp_valid); end
    checks++; if (bus.rsp_data !== 8'h65) begin errors++; $display("FAIL mid_rsp0_data: got %h exp 65", bus.rsp_data); end
    checks++; if (bus.req_ready !== 4'b0010) begin errors++; $display("FAIL mid_second_grant: got %b exp 0010", bus.req_ready); end
    tick();
    bus.req_valid = '0;
    #1;
    checks++; if (bus.rsp_data !== 8'h20) begin errors++; $display("FAIL mid_rsp1_data: got %h exp 20", bus.rsp_data); end
    tick();
  endtask

  task automatic test_wrap();
    do_reset();
    set_req(0, 8'h11, 8'h22);
    for (int k = 0; k < 17; k++) tick();
    bus.req_valid = '0;
    tick();
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL wrap_count: got %0d exp 1", op_count); end
    bus.rsp_ready = 4'b1110;
    set_req(0, 8'h11, 8'h22);
    tick();
    bus.req_valid = '0;
    tick();
    tick();
    checks++; if (op_count !== 4'd1) begin errors++; $display("FAIL wrap_hold_count: got %0d exp 1", op_count); end
    checks++; if (bus.rsp_valid !== 4'b0001) begin errors++; $display("FAIL wrap_hold_valid: got %b exp 0001", bus.rsp_valid); end
    bus.rsp_ready = '1;
    tick();
    checks++; if (op_count !== 4'd2) begin errors++; $display("FAIL wrap_after_count: got %0d exp 2", op_count); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wrap_after_busy: got %b exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_boundaries();
    test_reset_mid();
    test_wrap();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/min_share_arb.md
Name: min_share_arb

Overview:
- Round-robin arbiter that shares one registered 2-input minimum unit among NREQ requesters.
- Each requester presents an operand pair over a valid/ready handshake. The arbiter grants one requester per cycle and returns min(a,b) to that requester one cycle later through a per-requester response handshake.
- Sits between the compare datapath and its clients. It replaces one dedicated min unit per client.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits, unsigned.
- CNT_W, 16, width of the completed-operation counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester grant/accept, one-hot or zero.
- req_a  input  NREQ*WIDTH  operand a; requester i occupies bits [i*WIDTH +: WIDTH].
- req_b  input  NREQ*WIDTH  operand b; same packing as req_a.
- rsp_valid  output  NREQ  result valid; one-hot or zero, owner bit only.
- rsp_data  output  WIDTH  result, shared by all requesters; meaningful only while any rsp_valid is high.
- rsp_ready  input  NREQ  per-requester result accept.
- busy  output  1  high while a result is held unaccepted.
- op_count  output  CNT_W  number of results accepted since reset; wraps.

Behaviour:
- Reset (rst_n low, async), all of the following are cleared:
  - req_ready=0, rsp_valid=0, rsp_data=0, busy=0, op_count=0.
  - Held result is dropped.
  - RR pointer is set to NREQ-1, so requester 0 has first priority.
- State: one output slot {out_valid, owner[clog2(NREQ)], data[WIDTH]}. busy = out_valid.
- Accept condition: accept = out_valid && rsp_ready[owner].
- Slot free condition: can_issue = !out_valid || accept, so issuing and draining may occur in the same cycle.
- Grant, combinational:
  - If can_issue and any req_valid, grant the first valid requester searching ptr+1, ptr+2, … modulo NREQ.
  - req_ready = grant vector; otherwise all zero.
  - A handshake completes when req_valid[i] && req_ready[i].
- On a grant to requester g at edge t:
  - data <= (a_g > b_g) ? b_g : a_g. Unsigned compare; equal operands return a_g.
  - owner <= g, out_valid <= 1, ptr <= g.
- On accept without a new grant: out_valid <= 0. data holds its last value.
- rsp_valid[i] = out_valid && (owner == i).
- Latency: grant in cycle t gives rsp_valid in cycle t+1.
- Throughput: 1 op/cycle while rsp_ready of the current owner stays high.
- Backpressure: while the slot is held unaccepted, req_ready=0 for all requesters and rsp_data/owner remain stable.
- Requester obligations: req_valid must not drop and req_a/req_b must not change until the handshake completes. The arbiter relies on this but does not check it.
- Pointer moves only on a grant. With no request valid, the pointer is unchanged.
- op_count increments by 1 on each accept and wraps from 2^CNT_W-1 to 0.
- rsp_ready of a non-owner is ignored.

Decomposition:
- Shared package holds:
  - the rr_next function (next index after a pointer, modulo NREQ);
  - the localparam IDX_W = clog2(NREQ);
  - the min-select function.
- One sub-module, min2_reg: a registered unsigned minimum with an enable.
  - Inputs: clk, rst_n, en, a, b. Output: registered y. Reset value 0.
  - The arbiter instantiates it once, driven by the granted requester's operands through a NREQ:1 mux.

Test Plan:
- Single request: req0 a=0x30, b=0x12, rsp_ready=all 1 -> req_ready=0001 in that cycle; next cycle rsp_valid=0001, rsp_data=0x12, op_count=1.
- Full contention: all four req_valid held high, rsp_ready=all 1 -> grants in consecutive cycles 0,1,2,3,0,1; each result appears the cycle after its grant and equals min of that requester's pair.
- Backpressure: result pending for owner 1 with rsp_ready[1]=0 for 3 cycles, req0 and req2 valid -> req_ready=0 throughout, rsp_data stable. On raising rsp_ready[1], same cycle: accept plus grant to requester 2; the next cycle shows rsp_valid=0100.
- Boundaries:
  - a=0x55, b=0x55 -> 0x55.
  - a=0x00, b=0xFF -> 0x00.
  - a=0xFF, b=0x00 -> 0x00.
  - a=0x80, b=0x7F -> 0x7F (unsigned compare).
- Reset mid-operation: assert rst_n low off-edge while rsp_valid=0010 -> all outputs 0 immediately. After release with req1 and req0 both valid -> requester 0 granted first.
- Counter wrap: CNT_W=4, 17 accepted ops -> op_count reads 1. A cycle with rsp_valid high but owner's rsp_ready low -> no increment.
